// File: rtl/uart_receiver.sv
// 8N1 UART receive path: recovers bytes from rx_i using an OVERSAMPLE-x tick,
// sampling each bit at its centre. A framing error disarms start detection until the line idles high.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_tick_i,
  input  logic       rx_i,
  output logic [7:0] r_out_o,
  output logic       r_done_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic            rx_s;
  logic            armed_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_i};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      armed_reg    <= 1'b1;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      r_out_o      <= 8'h00;
      r_done_o     <= 1'b0;
      frame_err_o  <= 1'b0;
      rx_busy_o    <= 1'b0;
    end else begin
      r_done_o    <= 1'b0;
      frame_err_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_tick_i) begin
            if (rx_s) begin
              armed_reg <= 1'b1;
            end
            if (armed_reg && !rx_s) begin
              state_reg    <= START;
              tick_cnt_reg <= '0;
              rx_busy_o    <= 1'b1;
            end
          end
        end
        START: begin
          if (rx_tick_i) begin
            if (tick_cnt_reg == HALF_CNT) begin
              tick_cnt_reg <= '0;
              if (!rx_s) begin
                state_reg   <= DATA;
                bit_idx_reg <= 3'd0;
              end else begin
                // Line went back high before mid start bit: treat as a glitch.
                state_reg <= IDLE;
                rx_busy_o <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
          end
        end
        DATA: begin
          if (rx_tick_i) begin
            if (tick_cnt_reg == LAST_CNT) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {rx_s, shift_reg[7:1]};
              if (bit_idx_reg == 3'd7) begin
                state_reg <= STOP;
              end else begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
          end
        end
        STOP: begin
          if (rx_tick_i) begin
            if (tick_cnt_reg == LAST_CNT) begin
              tick_cnt_reg <= '0;
              state_reg    <= IDLE;
              rx_busy_o    <= 1'b0;
              if (rx_s) begin
                r_out_o  <= shift_reg;
                r_done_o <= 1'b1;
              end else begin
                frame_err_o <= 1'b1;
                armed_reg   <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          tick_cnt_reg <= '0;
          rx_busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: drives tick-aligned 8N1 frames and checks every cycle against
// an event-queue model (expected byte / framing error, exact latency from the start edge).
module tb_uart_receiver;

  logic       clk_i;
  logic       rst_i;
  logic       rx_tick_i;
  logic       rx_i;
  logic [7:0] r_out_o;
  logic       r_done_o;
  logic       frame_err_o;
  logic       rx_busy_o;

  uart_receiver #(.OVERSAMPLE(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_tick_i   (rx_tick_i),
    .rx_i        (rx_i),
    .r_out_o     (r_out_o),
    .r_done_o    (r_done_o),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         start_cyc;
    int         extra;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         tick_count = 0;
  bit         stall = 1'b0;
  logic [7:0] last_good = 8'h00;
  int         ref_lat = -1;
  int         done_cnt = 0;
  int         err_cnt = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rx_tick_i) tick_count <= tick_count + 1;
  end

  // Tick every 4th clock; phase freezes while stalled so the schedule shifts by the stall length.
  initial begin
    logic [1:0] phase;
    phase = 2'd0;
    rx_tick_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (stall) begin
        rx_tick_i = 1'b0;
      end else begin
        rx_tick_i = (phase == 2'd3);
        phase = phase + 2'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, outputs must match the event-queue model.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      last_good = 8'h00;
      check("reset_outputs", {r_out_o, r_done_o, frame_err_o, rx_busy_o}, 32'h0);
    end else if (r_done_o || frame_err_o) begin
      check("pulse_exclusive", 32'(r_done_o & frame_err_o), 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {r_done_o, frame_err_o}, 32'h0);
      end else begin
        exp_t e;
        int lat;
        e = exp_q.pop_front();
        lat = cyc - e.start_cyc;
        check("pulse_kind", {r_done_o, frame_err_o}, e.err ? 32'h1 : 32'h2);
        check("byte_value", r_out_o, e.err ? last_good : e.data);
        check("busy_at_end", rx_busy_o, 32'h0);
        if (ref_lat < 0) begin
          // 1 tick to detect + 152 ticks to the stop sample, 4 clocks per tick.
          check("first_latency", lat, 612);
          ref_lat = lat;
        end else begin
          check("latency", lat, ref_lat + e.extra);
        end
        if (e.err) err_cnt++;
        else begin
          done_cnt++;
          last_good = e.data;
        end
      end
    end else begin
      check("r_out_hold", r_out_o, last_good);
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stall_clks);
    exp_t e;
    e.data = b;
    e.err = !stop_ok;
    e.start_cyc = cyc;
    e.extra = stall_clks;
    exp_q.push_back(e);
    $display("frame: byte=%02h stop=%0d stall=%0d", b, stop_ok, stall_clks);
    rx_i = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      if (i == 3) begin
        wait_ticks(8);
        check("busy_mid_frame", rx_busy_o, 32'h1);
        if (stall_clks > 0) begin
          @(posedge clk_i);
          stall = 1'b1;
          repeat (stall_clks) @(posedge clk_i);
          stall = 1'b0;
        end
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    rx_i = stop_ok;
    wait_ticks(16);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_i = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_r_out", r_out_o, 32'h00);
    check("reset_busy", rx_busy_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    wait_ticks(4);

    // Good frame
    send_frame(8'hA5, 1'b1, 0);
    wait_ticks(4);
    check("good_frame_value", r_out_o, 32'hA5);
    check("good_frame_busy_low", rx_busy_o, 32'h0);

    // Start glitch
    rx_i = 1'b0;
    wait_ticks(4);
    check("glitch_busy", rx_busy_o, 32'h1);
    rx_i = 1'b1;
    wait_ticks(16);
    check("glitch_idle", rx_busy_o, 32'h0);
    check("glitch_r_out", r_out_o, 32'hA5);

    // Framing error, line held low, then a good frame
    send_frame(8'h3C, 1'b0, 0);
    wait_ticks(32);
    check("no_false_start", rx_busy_o, 32'h0);
    check("err_r_out_kept", r_out_o, 32'hA5);
    check("err_count", err_cnt, 32'd1);
    rx_i = 1'b1;
    wait_ticks(16);
    send_frame(8'h81, 1'b1, 0);
    wait_ticks(2);
    check("after_err_value", r_out_o, 32'h81);

    // Back-to-back frames
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h55, 1'b1, 0);
    wait_ticks(2);
    check("b2b_count", done_cnt - d0, 32'd3);
    check("b2b_last", r_out_o, 32'h55);

    // Reset during data bit 4 of 0x12
    $display("frame: byte=12 reset during bit 4");
    rx_i = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_i = ((8'h12 >> i) & 8'h01) != 8'h00;
      wait_ticks(16);
    end
    rx_i = 1'b0;
    wait_ticks(8);
    check("pre_reset_busy", rx_busy_o, 32'h1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 check("async_reset_outs", {r_out_o, r_done_o, frame_err_o, rx_busy_o}, 32'h0);
    rx_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    wait_ticks(4);
    send_frame(8'h34, 1'b1, 0);
    wait_ticks(2);
    check("after_reset_value", r_out_o, 32'h34);

    // Tick stall mid-frame
    send_frame(8'hC7, 1'b1, 100);
    wait_ticks(2);
    check("stall_value", r_out_o, 32'hC7);

    // Randomized frames, some with bad stop bits and random idle gaps
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, ($urandom_range(0, 3) == 0) ? 40 : 0);
      gap = ok ? $urandom_range(0, 20) : $urandom_range(1, 20);
      rx_i = 1'b1;
      wait_ticks(gap);
    end

    wait_ticks(20);
    check("pending_events", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
